ysyx_22040895_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer that owns the architectural PC and drives the instruction-memory request/response handshake. It supports one outstanding fetch and hands fetched instructions to decode over a valid/ready interface. It applies branch/jump/trap redirects from execute, including squashing in-flight fetches. It sits between the PC/branch logic and the IMEM port.

---
 rtl/ysyx_22040895_fetch_ctrl.sv | 109 ++++++++++
 tb/tb_ysyx_22040895_fetch_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040895_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one IMEM fetch at a time,
// holds the result for decode and applies execute/trap redirects.
module ysyx_22040895_fetch_ctrl #(
  parameter int                ADDR_W   = 64,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              misalign_err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    HALT = 3'd4
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_inc;
  logic [INST_W-1:0] inst_q;
  logic [ADDR_W-1:0] inst_pc_q;
  logic              drop_q;
  logic              misalign_q;
  logic              active;
  logic              redir_bad;

  assign pc_inc    = pc_q + ADDR_W'(4);
  assign active    = (state_q == REQ) || (state_q == WAIT) || (state_q == HOLD);
  assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      misalign_q <= 1'b0;
    end else if (active && redir_bad) begin
      // Unaligned target is fatal; pc keeps the last good value for debug.
      misalign_q <= 1'b1;
      state_q    <= HALT;
    end else begin
      unique case (state_q)
        IDLE: state_q <= REQ;
        REQ: begin
          if (redirect_valid) pc_q <= redirect_pc;
          else if (imem_req_ready) state_q <= WAIT;
        end
        WAIT: begin
          if (redirect_valid) begin
            pc_q <= redirect_pc;
            // A response landing with the redirect is the only one in flight,
            // so it is consumed here and nothing is left to drop.
            if (imem_resp_valid) begin
              drop_q  <= 1'b0;
              state_q <= REQ;
            end else begin
              drop_q <= 1'b1;
            end
          end else if (imem_resp_valid) begin
            if (drop_q) begin
              drop_q  <= 1'b0;
              state_q <= REQ;
            end else begin
              inst_q    <= imem_resp_data;
              inst_pc_q <= pc_q;
              state_q   <= HOLD;
            end
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            pc_q    <= redirect_pc;
            state_q <= REQ;
          end else if (inst_ready) begin
            pc_q    <= pc_inc;
            state_q <= REQ;
          end
        end
        HALT: state_q <= HALT;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_req_valid = (state_q == REQ) && !redirect_valid;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == HOLD);
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign misalign_err   = misalign_q;

endmodule

// File: tb/tb_ysyx_22040895_fetch_ctrl.sv
// Directed bench for the fetch sequencer with a one-slot IMEM responder and
// a scoreboard of instructions expected at the decode handshake.
module tb_ysyx_22040895_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        misalign_err;

  always #5 clk = ~clk;

  ysyx_22040895_fetch_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .misalign_err    (misalign_err)
  );

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          n_deliv = 0;
  int          lat = 1;
  bit          pend = 0;
  int          pend_cnt = 0;
  logic [63:0] pend_addr = '0;

  // Memory contents: 0x80000000 holds 0x00000013 (nop), others derive from addr.
  function automatic logic [31:0] mem(input logic [63:0] a);
    return a[31:0] + 32'h8000_0013;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes just before the edge, then update the IMEM model.
  task automatic tick();
    bit          acc;
    logic [63:0] a;
    exp_t        e;
    #1;
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    if (inst_valid && inst_ready && !redirect_valid && !rst) begin
      if (sb.size() == 0) begin
        chk("unexpected_delivery_pc", inst_pc, 64'hDEAD);
      end else begin
        e = sb.pop_front();
        chk("deliver_inst", {32'h0, inst}, {32'h0, e.inst});
        chk("deliver_pc", inst_pc, e.pc);
      end
      n_deliv++;
    end
    @(posedge clk);
    #1;
    if (imem_resp_valid) pend = 0;
    if (acc) begin
      pend = 1; pend_cnt = lat; pend_addr = a;
    end else if (pend) begin
      pend_cnt--;
    end
    if (rst) pend = 0;
    imem_resp_valid = pend && (pend_cnt <= 1);
    imem_resp_data  = imem_resp_valid ? mem(pend_addr) : 32'h0;
  endtask

  initial begin
    int cyc;
    logic [31:0] h_inst;
    logic [63:0] h_pc;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = '0; inst_ready = 1'b0;
    tick(); tick();
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, 64'h8000_0000);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_misalign", misalign_err, 0);

    rst = 1'b0; #1;
    chk("idle_no_req", imem_req_valid, 0);
    tick();
    chk("first_req_valid", imem_req_valid, 1);
    chk("first_req_addr", imem_req_addr, 64'h8000_0000);

    // Streaming: three nops at one per three cycles.
    imem_req_ready = 1'b1; inst_ready = 1'b1; lat = 1;
    sb.push_back('{32'h0000_0013, 64'h8000_0000});
    sb.push_back('{mem(64'h8000_0004), 64'h8000_0004});
    sb.push_back('{mem(64'h8000_0008), 64'h8000_0008});
    cyc = 0;
    while (n_deliv < 3 && cyc < 30) begin tick(); cyc++; end
    chk("stream_cycles", cyc, 9);
    chk("stream_next_addr", imem_req_addr, 64'h8000_000C);

    // Redirect while waiting; stale response comes two cycles later.
    lat = 3;
    tick();
    redirect_valid = 1'b1; redirect_pc = 64'h8000_1000;
    tick();
    redirect_valid = 1'b0; #1;
    chk("wait_redir_no_inst", inst_valid, 0);
    chk("wait_redir_no_req", imem_req_valid, 0);
    tick();
    chk("stale_resp_no_inst", inst_valid, 0);
    tick();
    chk("after_drop_inst", inst_valid, 0);
    chk("after_drop_req_valid", imem_req_valid, 1);
    chk("after_drop_addr", imem_req_addr, 64'h8000_1000);

    // Redirect in the same cycle as the response.
    lat = 1;
    tick();
    redirect_valid = 1'b1; redirect_pc = 64'h8000_2000;
    tick();
    redirect_valid = 1'b0; #1;
    chk("same_cyc_inst", inst_valid, 0);
    chk("same_cyc_req_valid", imem_req_valid, 1);
    chk("same_cyc_addr", imem_req_addr, 64'h8000_2000);
    inst_ready = 1'b0;
    tick(); tick();
    chk("next_resp_valid", inst_valid, 1);
    chk("next_resp_inst", {32'h0, inst}, {32'h0, mem(64'h8000_2000)});
    chk("next_resp_pc", inst_pc, 64'h8000_2000);

    // Backpressure: held instruction stays put, no new fetch.
    h_inst = inst; h_pc = inst_pc;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", inst_valid, 1);
      chk("hold_inst", {32'h0, inst}, {32'h0, h_inst});
      chk("hold_pc", inst_pc, h_pc);
      chk("hold_no_req", imem_req_valid, 0);
    end
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_3000;
    tick();
    redirect_valid = 1'b0; #1;
    chk("squash_inst_valid", inst_valid, 0);
    chk("squash_req_valid", imem_req_valid, 1);
    chk("squash_addr", imem_req_addr, 64'h8000_3000);

    // PC wraps to zero after the top word.
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC; #1;
    chk("redir_blocks_req", imem_req_valid, 0);
    tick();
    redirect_valid = 1'b0; #1;
    chk("wrap_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    sb.push_back('{mem(64'hFFFF_FFFF_FFFF_FFFC), 64'hFFFF_FFFF_FFFF_FFFC});
    tick(); tick(); tick();
    chk("wrap_next_valid", imem_req_valid, 1);
    chk("wrap_next_addr", imem_req_addr, 64'h0);
    chk("deliv_count", n_deliv, 4);

    // Misaligned redirect halts until reset.
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0002;
    tick();
    redirect_valid = 1'b0; #1;
    chk("misalign_set", misalign_err, 1);
    chk("misalign_pc_kept", imem_req_addr, 64'h0);
    for (int i = 0; i < 8; i++) begin
      redirect_valid = (i == 3); redirect_pc = 64'h8000_4000;
      tick();
      chk("halt_no_req", imem_req_valid, 0);
      chk("halt_no_inst", inst_valid, 0);
      chk("halt_sticky", misalign_err, 1);
    end
    redirect_valid = 1'b0;
    chk("halt_ignores_redir", imem_req_addr, 64'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    chk("rerst_misalign", misalign_err, 0);
    chk("rerst_addr", imem_req_addr, 64'h8000_0000);
    chk("rerst_no_req", imem_req_valid, 0);
    tick();
    chk("rerst_req_valid", imem_req_valid, 1);
    chk("rerst_req_addr", imem_req_addr, 64'h8000_0000);

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
